// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - shared op codes, state encodings and latency defaults for the MD unit
package md_sequencer_pkg;

  // Multiply/divide operation codes issued by control in the E stage
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  // Sequencer states: BUSY while a mult/div result is pending
  typedef enum logic {
    MD_S_IDLE = 1'b0,
    MD_S_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 32-bit mult/div producing HI/LO results
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        b_zero;
  logic        div_ovf;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned product equal to the signed product.
  assign prod_u = {32'b0, a} * {32'b0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Signed division is done on magnitudes so that MIN/-1 never reaches a
  // native signed divide; quotient truncates toward zero and the remainder
  // follows the dividend's sign.
  assign a_mag   = a[31] ? (32'd0 - a) : a;
  assign b_mag   = b[31] ? (32'd0 - b) : b;
  assign quo_mag = a_mag / b_mag;
  assign rem_mag = a_mag % b_mag;
  assign quo_s   = (a[31] ^ b[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = a[31] ? (32'd0 - rem_mag) : rem_mag;
  assign quo_u   = a / b;
  assign rem_u   = a % b;

  assign b_zero  = (b == 32'd0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Select the result pair for the requested operation; non-arith ops yield zero
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      MD_DIVU: begin
        if (b_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - E-stage multiply/divide sequencer owning HI/LO
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo,
  input  logic        stop,
  input  logic        restore,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e         state_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       hi_q;
  logic [31:0]       lo_q;
  logic [31:0]       pend_hi_q;
  logic [31:0]       pend_lo_q;
  logic [31:0]       shadow_hi_q;
  logic [31:0]       shadow_lo_q;
  logic              shadow_valid_q;

  logic [31:0]       res_hi;
  logic [31:0]       res_lo;
  logic              is_arith;
  logic              is_div;
  logic              is_mt;
  logic              idle;
  logic              start;
  logic              restore_en;
  logic              mt_wr;

  md_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign is_div   = (op == MD_DIV) || (op == MD_DIVU);
  assign is_arith = is_div || (op == MD_MULT) || (op == MD_MULTU);
  assign is_mt    = (op == MD_MTHI) || (op == MD_MTLO);
  assign idle     = (state_q == MD_S_IDLE);

  // A restore only acts when there is something to roll back; when it does,
  // it owns HI/LO this cycle, so a same-cycle MTHI/MTLO is dropped.
  assign restore_en = restore && shadow_valid_q;
  assign start      = idle && is_arith && !stop;
  assign mt_wr      = idle && is_mt && !stop && !restore_en;

  // FSM, latency counter, pending result, shadow and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= MD_S_IDLE;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
      hi_q           <= 32'd0;
      lo_q           <= 32'd0;
      pend_hi_q      <= 32'd0;
      pend_lo_q      <= 32'd0;
      shadow_hi_q    <= 32'd0;
      shadow_lo_q    <= 32'd0;
      shadow_valid_q <= 1'b0;
    end else begin
      case (state_q)
        MD_S_IDLE: begin
          if (start) begin
            pend_hi_q      <= res_hi;
            pend_lo_q      <= res_lo;
            cnt_q          <= is_div ? DIV_LOAD : MULT_LOAD;
            state_q        <= MD_S_BUSY;
            busy_q         <= 1'b1;
            shadow_valid_q <= 1'b0;
          end else if (mt_wr) begin
            shadow_hi_q    <= hi_q;
            shadow_lo_q    <= lo_q;
            shadow_valid_q <= 1'b1;
            if (op == MD_MTHI) begin
              hi_q <= a;
            end else begin
              lo_q <= a;
            end
          end
        end
        MD_S_BUSY: begin
          if (stop) begin
            state_q   <= MD_S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
          end else if (cnt_q == '0) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            state_q <= MD_S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= MD_S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
      // Roll-back takes priority over every other HI/LO update this cycle
      if (restore_en) begin
        hi_q           <= shadow_hi_q;
        lo_q           <= shadow_lo_q;
        shadow_valid_q <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign out  = hilo ? lo_q : hi_q;

endmodule
